// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and channel FSM state encodings.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_WAIT_W  = 2'd1,
    W_WAIT_AW = 2'd2,
    W_RESP    = 2'd3
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Response code for an access, selected by whether its register index exists.
  function automatic logic [1:0] resp_for(input logic in_range);
    return in_range ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: DEPTH word registers with byte-strobe writes,
// independent write/read channels, OKAY in range and SLVERR out of range.
// All handshake/response outputs are registered, so they read 0 during reset
// and the ready signals rise on the first clock edge after reset release.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int DEPTH      = 16
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [IW:0] DEPTH_L = (IW + 1)'(DEPTH);

  w_state_e              w_state_r, w_next_s;
  r_state_e              r_state_r, r_next_s;
  logic                  awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
  logic [RESP_WIDTH-1:0] bresp_r, rresp_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [ADDR_WIDTH-1:0] aw_addr_r;
  logic [DATA_WIDTH-1:0] w_data_r;
  logic [NB-1:0]         w_strb_r;
  logic [DATA_WIDTH-1:0] regs_r [DEPTH];

  logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic [ADDR_WIDTH-1:0] commit_addr_s;
  logic [DATA_WIDTH-1:0] commit_data_s;
  logic [NB-1:0]         commit_strb_s;
  logic [IW-1:0]         commit_idx_s, ar_idx_s;
  logic                  commit_in_range_s, ar_in_range_s;
  logic [DATA_WIDTH-1:0] ar_word_s;
  logic                  unused_s;

  // The strobe MSB and the byte offset bits carry no meaning for word registers.
  assign unused_s = ^{s_axi_wstrb[NB], s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign aw_hs_s = s_axi_awvalid & awready_r;
  assign w_hs_s  = s_axi_wvalid  & wready_r;
  assign ar_hs_s = s_axi_arvalid & arready_r;

  assign commit_idx_s      = commit_addr_s[ADDR_WIDTH-1:2];
  assign commit_in_range_s = ({1'b0, commit_idx_s} < DEPTH_L);
  assign ar_idx_s          = s_axi_araddr[ADDR_WIDTH-1:2];
  assign ar_in_range_s     = ({1'b0, ar_idx_s} < DEPTH_L);

  // Write FSM next state; picks address/data from the latch or the live bus at commit.
  always_comb begin
    w_next_s      = w_state_r;
    commit_s      = 1'b0;
    commit_addr_s = s_axi_awaddr;
    commit_data_s = s_axi_wdata;
    commit_strb_s = s_axi_wstrb[NB-1:0];
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          commit_s = 1'b1;
          w_next_s = W_RESP;
        end else if (aw_hs_s) begin
          w_next_s = W_WAIT_W;
        end else if (w_hs_s) begin
          w_next_s = W_WAIT_AW;
        end else begin
          w_next_s = W_IDLE;
        end
      end
      W_WAIT_W: begin
        commit_addr_s = aw_addr_r;
        if (w_hs_s) begin
          commit_s = 1'b1;
          w_next_s = W_RESP;
        end else begin
          w_next_s = W_WAIT_W;
        end
      end
      W_WAIT_AW: begin
        commit_data_s = w_data_r;
        commit_strb_s = w_strb_r;
        if (aw_hs_s) begin
          commit_s = 1'b1;
          w_next_s = W_RESP;
        end else begin
          w_next_s = W_WAIT_AW;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_next_s = W_IDLE;
        end else begin
          w_next_s = W_RESP;
        end
      end
      default: w_next_s = W_IDLE;
    endcase
  end

  // Write state, registered handshake outputs and the address/data holding latches.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= '0;
      aw_addr_r <= '0;
      w_data_r  <= '0;
      w_strb_r  <= '0;
    end else begin
      w_state_r <= w_next_s;
      awready_r <= (w_next_s == W_IDLE) || (w_next_s == W_WAIT_AW);
      wready_r  <= (w_next_s == W_IDLE) || (w_next_s == W_WAIT_W);
      bvalid_r  <= (w_next_s == W_RESP);
      if (commit_s) bresp_r <= RESP_WIDTH'(resp_for(commit_in_range_s));
      if (aw_hs_s) aw_addr_r <= s_axi_awaddr;
      if (w_hs_s) begin
        w_data_r <= s_axi_wdata;
        w_strb_r <= s_axi_wstrb[NB-1:0];
      end
    end
  end

  // Register array: cleared on reset, byte-merged on an in-range commit.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < DEPTH; i++) regs_r[i] <= '0;
    end else if (commit_s && commit_in_range_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int b = 0; b < NB; b++) begin
          if ((commit_idx_s == IW'(i)) && commit_strb_s[b]) begin
            regs_r[i][8*b +: 8] <= commit_data_s[8*b +: 8];
          end
        end
      end
    end
  end

  // Read mux over the register array for the live AR index.
  always_comb begin
    ar_word_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ar_word_s = (ar_idx_s == IW'(i)) ? regs_r[i] : ar_word_s;
    end
  end

  // Read FSM next state.
  always_comb begin
    r_next_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) r_next_s = R_DATA;
        else         r_next_s = R_IDLE;
      end
      R_DATA: begin
        if (s_axi_rready) r_next_s = R_IDLE;
        else              r_next_s = R_DATA;
      end
      default: r_next_s = R_IDLE;
    endcase
  end

  // Read state and registered response; array is sampled before any same-edge write lands.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= '0;
      rresp_r   <= '0;
    end else begin
      r_state_r <= r_next_s;
      arready_r <= (r_next_s == R_IDLE);
      rvalid_r  <= (r_next_s == R_DATA);
      if (ar_hs_s) begin
        rdata_r <= ar_in_range_s ? ar_word_s : '0;
        rresp_r <= RESP_WIDTH'(resp_for(ar_in_range_s));
      end
    end
  end

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;

endmodule
